// File: rtl/spi_slave_core_if.sv
// Bus bundle for spi_slave_core: the byte handshake toward the command layer
// plus the four SPI pins. The core uses the slave view; the surrounding logic
// (or a bench) drives the master view.
interface spi_slave_core_if;
    logic       o_rx_data_valid;
    logic [7:0] o_rx_byte;
    logic       i_tx_data_valid;
    logic [7:0] i_tx_byte;
    logic       i_spi_sck;
    logic       o_spi_miso;
    logic       i_spi_mosi;
    logic       i_spi_cs_b;

    modport slave (
        output o_rx_data_valid,
        output o_rx_byte,
        output o_spi_miso,
        input  i_tx_data_valid,
        input  i_tx_byte,
        input  i_spi_sck,
        input  i_spi_mosi,
        input  i_spi_cs_b
    );

    modport master (
        input  o_rx_data_valid,
        input  o_rx_byte,
        input  o_spi_miso,
        output i_tx_data_valid,
        output i_tx_byte,
        output i_spi_sck,
        output i_spi_mosi,
        output i_spi_cs_b
    );
endinterface

// File: rtl/spi_slave_core.sv
// Byte-oriented SPI mode-0 slave, MSB first. SCK/MOSI/CS_b are oversampled in
// the system clock domain; each received byte is reported with a one-cycle
// strobe and a response byte can be queued for the next byte slot.
module spi_slave_core (
    input  logic              i_sys_clk,
    input  logic              i_rst_b,
    spi_slave_core_if.slave   bus
);

    // Synchronizer and edge-history flops
    logic sck_meta_q, sck_sync_q, sck_hist_q;
    logic mosi_meta_q, mosi_sync_q;
    logic cs_meta_q, cs_sync_q;

    // Protocol state
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] rx_shift_q,  rx_shift_d;
    logic [7:0] rx_byte_q,   rx_byte_d;
    logic       rx_vld_q,    rx_vld_d;
    logic [7:0] tx_shift_q,  tx_shift_d;
    logic       pend_vld_q,  pend_vld_d;
    logic [7:0] pend_byte_q, pend_byte_d;

    logic       sel;
    logic       sck_rise;
    logic       sck_fall;
    logic       wrap;
    logic [7:0] rx_next;

    assign sel      = ~cs_sync_q;
    assign sck_rise =  sck_sync_q & ~sck_hist_q;
    assign sck_fall = ~sck_sync_q &  sck_hist_q;
    assign wrap     = sel & sck_rise & (bit_cnt_q == 3'd7);
    assign rx_next  = {rx_shift_q[6:0], mosi_sync_q};

    // Bring the asynchronous SPI pins into the system clock domain
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_hist_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            cs_meta_q   <= 1'b0;
            cs_sync_q   <= 1'b0;
        end else begin
            sck_meta_q  <= bus.i_spi_sck;
            sck_sync_q  <= sck_meta_q;
            sck_hist_q  <= sck_sync_q;
            mosi_meta_q <= bus.i_spi_mosi;
            mosi_sync_q <= mosi_meta_q;
            cs_meta_q   <= bus.i_spi_cs_b;
            cs_sync_q   <= cs_meta_q;
        end
    end

    // Next-state logic for bit counting, RX assembly and TX shifting
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_vld_d    = 1'b0;
        tx_shift_d  = tx_shift_q;
        pend_vld_d  = pend_vld_q;
        pend_byte_d = pend_byte_q;

        if (!sel) begin
            // Deselected: drop any partial byte and any queued response.
            bit_cnt_d  = 3'd0;
            tx_shift_d = 8'h00;
            pend_vld_d = 1'b0;
        end else if (sck_rise) begin
            rx_shift_d = rx_next;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (wrap) begin
                rx_byte_d  = rx_next;
                rx_vld_d   = 1'b1;
                tx_shift_d = pend_vld_q ? pend_byte_q : 8'h00;
                pend_vld_d = 1'b0;
            end
        end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
            // The fall right after a byte boundary keeps the fresh MSB in place.
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end

        // A load strobe in the inter-byte gap goes straight to the shifter;
        // anywhere else it waits for the next boundary.
        if (bus.i_tx_data_valid) begin
            if (sel && ((bit_cnt_q == 3'd0) || wrap)) begin
                tx_shift_d = bus.i_tx_byte;
                pend_vld_d = 1'b0;
            end else begin
                pend_vld_d  = 1'b1;
                pend_byte_d = bus.i_tx_byte;
            end
        end
    end

    // Protocol state registers
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            rx_byte_q   <= 8'h00;
            rx_vld_q    <= 1'b0;
            tx_shift_q  <= 8'h00;
            pend_vld_q  <= 1'b0;
            pend_byte_q <= 8'h00;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_vld_q    <= rx_vld_d;
            tx_shift_q  <= tx_shift_d;
            pend_vld_q  <= pend_vld_d;
            pend_byte_q <= pend_byte_d;
        end
    end

    assign bus.o_rx_data_valid = rx_vld_q;
    assign bus.o_rx_byte       = rx_byte_q;
    assign bus.o_spi_miso      = sel & tx_shift_q[7];

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a mode-0 SPI master (half-period of
// 8 system clocks) plus a strobe monitor.
module tb_spi_slave_core;

    logic clk;
    logic rst_b;

    spi_slave_core_if bus ();

    spi_slave_core dut (
        .i_sys_clk (clk),
        .i_rst_b   (rst_b),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Strobe monitor: counts pulses, records bytes, tracks longest pulse
    int         vld_cnt = 0;
    int         run     = 0;
    int         max_run = 0;
    logic [7:0] rxq[$];

    // Observe the receive strobe on the inactive edge
    always @(negedge clk) begin
        if (bus.o_rx_data_valid === 1'b1) begin
            vld_cnt = vld_cnt + 1;
            rxq.push_back(bus.o_rx_byte);
            run = run + 1;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            bus.i_spi_sck  = 1'b0;
            bus.i_spi_mosi = mo[i];
            repeat (8) @(negedge clk);
            mi[i] = bus.o_spi_miso;
            bus.i_spi_sck = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic tx_pulse(input logic [7:0] b);
        bus.i_tx_byte       = b;
        bus.i_tx_data_valid = 1'b1;
        @(negedge clk);
        bus.i_tx_data_valid = 1'b0;
    endtask

    function automatic logic [7:0] rx_at(input int idx);
        if (idx < rxq.size()) return rxq[idx];
        return 8'hxx;
    endfunction

    logic [7:0] mi;
    logic       got;

    initial begin
        rst_b               = 1'b0;
        bus.i_spi_sck       = 1'b0;
        bus.i_spi_mosi      = 1'b0;
        bus.i_spi_cs_b      = 1'b1;
        bus.i_tx_data_valid = 1'b0;
        bus.i_tx_byte       = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.o_rx_data_valid, 1'b0);
        check("rst_byte",  bus.o_rx_byte, 8'h00);
        check("rst_miso",  bus.o_spi_miso, 1'b0);
        rst_b = 1'b1;
        repeat (4) @(negedge clk);

        // Single received byte, nothing loaded for transmit
        bus.i_spi_cs_b = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'hA5, mi);
        repeat (6) @(negedge clk);
        check("rx1_count", vld_cnt, 1);
        check("rx1_byte",  rx_at(0), 8'hA5);
        check("rx1_hold",  bus.o_rx_byte, 8'hA5);
        check("rx1_miso",  mi, 8'h00);

        // Read: command byte, then response loaded 3 cycles after its strobe
        got = 1'b0;
        fork
            spi_byte(8'h03, mi);
            begin
                for (int k = 0; k < 200 && !got; k++) begin
                    @(negedge clk);
                    if (bus.o_rx_data_valid === 1'b1) got = 1'b1;
                end
                check("rd_strobe_seen", got, 1'b1);
                repeat (3) @(negedge clk);
                tx_pulse(8'h5C);
            end
        join
        check("rd_cmd_byte", rx_at(1), 8'h03);
        spi_byte(8'h00, mi);
        repeat (6) @(negedge clk);
        check("rd_miso",  mi, 8'h5C);
        check("rd_count", vld_cnt, 3);
        check("rd_byte2", rx_at(2), 8'h00);

        // Pending: load arrives after the third bit of a byte
        fork
            spi_byte(8'h11, mi);
            begin
                repeat (44) @(negedge clk);
                tx_pulse(8'hF0);
            end
        join
        check("pend_cur_miso", mi, 8'h00);
        spi_byte(8'h22, mi);
        check("pend_next_miso", mi, 8'hF0);
        spi_byte(8'h33, mi);
        check("pend_third_miso", mi, 8'h00);
        repeat (6) @(negedge clk);
        check("pend_count", vld_cnt, 6);
        check("pend_bytes", {rx_at(3), rx_at(4), rx_at(5)}, 24'h112233);

        // Abort after 5 bits, then a clean byte
        for (int i = 0; i < 5; i++) begin
            bus.i_spi_sck  = 1'b0;
            bus.i_spi_mosi = 1'b1;
            repeat (8) @(negedge clk);
            bus.i_spi_sck = 1'b1;
            repeat (8) @(negedge clk);
        end
        bus.i_spi_cs_b = 1'b1;
        bus.i_spi_sck  = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_strobe", vld_cnt, 6);
        check("abort_desel_miso", bus.o_spi_miso, 1'b0);
        bus.i_spi_cs_b = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'h81, mi);
        repeat (6) @(negedge clk);
        check("abort_count", vld_cnt, 7);
        check("abort_byte",  rx_at(6), 8'h81);

        // Back-to-back bytes in one frame
        spi_byte(8'h01, mi);
        spi_byte(8'h02, mi);
        spi_byte(8'h04, mi);
        spi_byte(8'h08, mi);
        repeat (6) @(negedge clk);
        check("b2b_count", vld_cnt, 11);
        check("b2b_bytes", {rx_at(7), rx_at(8), rx_at(9), rx_at(10)}, 32'h01020408);
        check("strobe_width", max_run, 1);

        // Direct load in the gap shows the MSB on the next cycle
        repeat (4) @(negedge clk);
        tx_pulse(8'hFF);
        check("direct_miso", bus.o_spi_miso, 1'b1);

        // Reset in the middle of a byte clears outputs at once
        bus.i_spi_sck  = 1'b0;
        bus.i_spi_mosi = 1'b1;
        repeat (8) @(negedge clk);
        bus.i_spi_sck = 1'b1;
        repeat (8) @(negedge clk);
        bus.i_spi_sck = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_miso", bus.o_spi_miso, 1'b1);
        rst_b = 1'b0;
        #1;
        check("midrst_miso",  bus.o_spi_miso, 1'b0);
        check("midrst_byte",  bus.o_rx_byte, 8'h00);
        check("midrst_valid", bus.o_rx_data_valid, 1'b0);
        bus.i_spi_cs_b = 1'b1;
        repeat (4) @(negedge clk);
        rst_b = 1'b1;
        repeat (20) @(negedge clk);
        check("postrst_count", vld_cnt, 11);
        check("postrst_byte",  bus.o_rx_byte, 8'h00);
        check("postrst_miso",  bus.o_spi_miso, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
